// File: rtl/ca_engine.sv
// Sequential 1-D cellular-automaton engine: loads a cell row and rule table,
// then steps the row forward a programmed number of generations, one per clock.
module ca_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NBR   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_state,
  input  logic [(1<<NBR)-1:0]    rule,
  input  logic                   wrap_mode,
  input  logic                   start,
  input  logic [CNT_W-1:0]       gens,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       state_out,
  output logic [CNT_W-1:0]       gen_count
);

  localparam int unsigned RULE_W = 1 << NBR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [WIDTH-1:0]  cells_q, cells_d;
  logic [RULE_W-1:0] rule_q, rule_d;
  logic [CNT_W-1:0]  gens_q, gens_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic [WIDTH-1:0]  next_gen;

  // Window lookup per cell; taps past the top edge wrap or read as zero.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [NBR-1:0] idx;
    for (genvar k = 0; k < NBR; k++) begin : g_tap
      if (i + k < WIDTH) begin : g_in
        assign idx[k] = cells_q[i + k];
      end else begin : g_edge
        assign idx[k] = wrap_mode & cells_q[(i + k) % WIDTH];
      end
    end
    assign next_gen[i] = rule_q[idx];
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      cells_q <= '0;
      rule_q  <= '0;
      gens_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cells_q <= cells_d;
      rule_q  <= rule_d;
      gens_q  <= gens_d;
      cnt_q   <= cnt_d;
      busy_q  <= (fsm_d == RUN);
      done_q  <= (fsm_d == DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    fsm_d   = fsm_q;
    cells_d = cells_q;
    rule_d  = rule_q;
    gens_d  = gens_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (load) begin
          cells_d = load_state;
          rule_d  = rule;
        end else if (start) begin
          gens_d = gens;
          cnt_d  = '0;
          fsm_d  = (gens != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        cells_d = next_gen;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q + CNT_W'(1) == gens_q) fsm_d = DONE;
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = cells_q;
  assign gen_count = cnt_q;

endmodule
